// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that sequences iaddr/eram on the shared RAM bus and hands ir to decode.
// Optional feature: define FETCH_JUMP_EN to honour jmp/jmp_addr.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [15:0] data,
  output logic        iaddr,
  output logic        eram,
  output logic        iram,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        halt,
  input  logic        jmp,
  input  logic [15:0] jmp_addr,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready
);
  typedef enum logic [1:0] {REQ, ADDR, READ, HOLD} state_t;
  state_t      r_state, w_next;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_valid;
  logic        w_jmp;
  logic        w_unused;
`ifdef FETCH_JUMP_EN
  assign w_jmp = jmp;
`else
  assign w_jmp = 1'b0;
`endif
  assign w_unused = ^{jmp, jmp_addr[15:7]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      REQ:     w_next = (bus_gnt && !halt) ? ADDR : REQ;
      ADDR:    w_next = bus_gnt ? READ : REQ;
      READ:    w_next = bus_gnt ? HOLD : REQ;
      default: w_next = ir_ready ? REQ : HOLD;
    endcase
    if (w_jmp) w_next = REQ;
  end
  // strobes drop with the grant so an aborted fetch never touches the RAM
  assign bus_req  = rst_n && ((r_state == REQ) ? !halt : (r_state != HOLD));
  assign iaddr    = (r_state == ADDR) && bus_gnt;
  assign eram     = (r_state == READ) && bus_gnt;
  assign iram     = 1'b0;
  assign data     = iaddr ? {9'b0, r_pc} : 16'bz;
  assign pc       = {9'b0, r_pc};
  assign ir       = r_ir;
  assign ir_valid = r_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= REQ;
      r_pc    <= 7'd0;
      r_ir    <= 16'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_jmp) begin
        r_pc    <= jmp_addr[6:0];
        r_valid <= 1'b0;
      end else if (eram) begin
        r_ir    <= data;
        r_valid <= 1'b1;
        r_pc    <= r_pc + 7'd1;
      end else if (r_state == HOLD && ir_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural shared-bus RAM.
module tb_fetch_unit;
  logic        clk = 0, rst_n = 0, bus_gnt = 1, halt = 0, jmp = 0, ir_ready = 0;
  logic [15:0] jmp_addr = 16'd0;
  wire  [15:0] data;
  logic        iaddr, eram, iram, bus_req, ir_valid;
  logic [15:0] pc, ir;
  logic [15:0] mem [128];
  logic [6:0]  ram_addr = 7'd0;
  logic [6:0]  mp = 7'd0, q_pc = 7'd0;
  logic [15:0] last_ir = 16'd0;
  logic [31:0] sb_q [$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .data(data), .iaddr(iaddr), .eram(eram), .iram(iram),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .halt(halt), .jmp(jmp), .jmp_addr(jmp_addr),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  always @(posedge clk) if (iaddr) ram_addr <= data[6:0];
  assign data = eram ? mem[ram_addr] : 16'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [31:0] e;
    if (iaddr || eram) check("strobe_excl", {31'd0, iaddr & eram}, 32'd0);
    if (iaddr) check("addr_bus", {16'd0, data}, {25'd0, mp});
    if (ir_valid && ir_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        check("sb_ir", {16'd0, ir}, {16'd0, e[31:16]});
        check("sb_pc", {16'd0, pc}, {16'd0, e[15:0]});
        mp = e[6:0];
        last_ir = ir;
      end
    end
  end

  task automatic push_exp(input int k);
    for (int i = 0; i < k; i++) begin
      sb_q.push_back({mem[q_pc], 9'b0, q_pc + 7'd1});
      q_pc = q_pc + 7'd1;
    end
  endtask

  task automatic drain();
    bus_gnt  = 1;
    ir_ready = 1;
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_timeout", sb_q.size(), 32'd0);
    @(posedge clk); #1;
    ir_ready = 0;
    bus_gnt  = 0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !ir_valid; i++) @(negedge clk);
    check("valid_timeout", {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic wait_iaddr();
    for (int i = 0; i < 50 && !iaddr; i++) @(negedge clk);
    check("iaddr_timeout", {31'd0, iaddr}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0]   = 16'h1234;
    mem[127] = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_strobes", {29'd0, iaddr, eram, bus_req}, 32'd0);
    // basic fetch of word 0, held without ir_ready
    push_exp(1);
    @(posedge clk); #1;
    rst_n = 1;
    wait_iaddr();
    check("basic_addr", {16'd0, data}, 32'd0);
    check("basic_eram_off", {31'd0, eram}, 32'd0);
    @(negedge clk);
    check("basic_eram_on", {30'd0, eram, iaddr}, 32'd2);
    check("basic_iram", {31'd0, iram}, 32'd0);
    @(negedge clk);
    check("basic_valid", {31'd0, ir_valid}, 32'd1);
    check("basic_ir", {16'd0, ir}, 32'h1234);
    check("basic_pc", {16'd0, pc}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("hold_ir", {15'd0, ir_valid, ir}, 32'h11234);
      check("hold_bus_req", {31'd0, bus_req}, 32'd0);
    end
    @(posedge clk); #1;
    drain();
    // back-to-back sequential fetches
    push_exp(5);
    drain();
    // grant loss during READ
    push_exp(1);
    @(posedge clk); #1;
    bus_gnt = 1;
    wait_iaddr();
    @(posedge clk); #1;
    bus_gnt = 0;
    @(negedge clk);
    check("gl_eram", {31'd0, eram}, 32'd0);
    check("gl_bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    check("gl_pc", {16'd0, pc}, {25'd0, mp});
    check("gl_ir", {16'd0, ir}, {16'd0, last_ir});
    check("gl_valid", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    drain();
    // jump while holding a word
    push_exp(1);
    @(posedge clk); #1;
    bus_gnt = 1;
    wait_valid();
    @(posedge clk); #1;
    jmp = 1;
    jmp_addr = 16'hFF40;
`ifdef FETCH_JUMP_EN
    void'(sb_q.pop_back());
    q_pc = 7'h40;
    mp = 7'h40;
`endif
    @(posedge clk); #1;
    jmp = 0;
    bus_gnt = 0;
    @(negedge clk);
`ifdef FETCH_JUMP_EN
    check("jmp_valid", {31'd0, ir_valid}, 32'd0);
    check("jmp_pc", {16'd0, pc}, 32'h40);
    push_exp(1);
`else
    check("nojmp_valid", {31'd0, ir_valid}, 32'd1);
    check("nojmp_pc", {16'd0, pc}, {25'd0, q_pc});
`endif
    @(posedge clk); #1;
    drain();
    // halt blocks leaving REQ
    halt = 1;
    bus_gnt = 1;
    repeat (10) begin
      @(negedge clk);
      check("halt_quiet", {29'd0, bus_req, iaddr, eram}, 32'd0);
    end
    push_exp(1);
    @(posedge clk); #1;
    halt = 0;
    @(posedge clk);
    @(negedge clk);
    check("halt_resume", {31'd0, iaddr}, 32'd1);
    @(posedge clk); #1;
    drain();
    // walk up to pc 127, then wrap
    push_exp(int'(7'd127 - q_pc));
    drain();
    check("pre_wrap_pc", {16'd0, pc}, 32'd127);
    push_exp(1);
    drain();
    check("wrap_ir", {16'd0, ir}, 32'hBEEF);
    check("wrap_pc", {16'd0, pc}, 32'd0);
    push_exp(1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
